fetch_decode_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register of the 5-stage pipelined MIPS core.

---
 rtl/fetch_decode_stage_if.sv | 32 +++
 rtl/fetch_decode_stage.sv | 84 ++++++++
 tb/tb_fetch_decode_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_stage_if.sv
// Signal bundle between the fetch/decode stage and its surroundings
// (hazard unit, decode-stage redirect logic, instruction memory, control decoder).
interface fetch_decode_stage_if #(
    parameter int CNT_W = 16
);
    // No valid/ready handshake on this bundle: StallF/StallD are the only flow
    // control, and a stalled register holds its value across the edge.
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             PCSrcD;
    logic [31:0]      PCBranchD;
    logic             JumpD;
    logic [31:0]      InstrF;
    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCPlus4D;
    logic [5:0]       OpD;
    logic [5:0]       FunctD;
    logic             ValidD;
    logic [CNT_W-1:0] BubbleCount;

    modport master (
        output StallF, StallD, FlushD, PCSrcD, PCBranchD, JumpD, InstrF,
        input  PCF, InstrD, PCPlus4D, OpD, FunctD, ValidD, BubbleCount
    );

    modport slave (
        input  StallF, StallD, FlushD, PCSrcD, PCBranchD, JumpD, InstrF,
        output PCF, InstrD, PCPlus4D, OpD, FunctD, ValidD, BubbleCount
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID pipeline register: PC with branch/jump redirect,
// stall/flush handling, and a saturating count of bubbles loaded into decode.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_stage_if.slave  bus
);
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_plus4_d_q, pc_plus4_d_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic [31:0]      pc_plus4_f;
    logic [31:0]      jump_target;

    assign pc_plus4_f  = pc_q + 32'd4;
    assign jump_target = {pc_plus4_d_q[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d      = valid_q;
        bubble_d     = bubble_q;

        // A stalled fetch drops any redirect; the instruction causing it is
        // held in decode and re-issues the redirect once the stall clears.
        if (!bus.StallF) begin
            if (bus.JumpD) begin
                pc_d = jump_target;
            end else if (bus.PCSrcD) begin
                pc_d = bus.PCBranchD;
            end else begin
                pc_d = pc_plus4_f;
            end
        end

        if (bus.StallD) begin
            instr_d      = instr_q;
            pc_plus4_d_d = pc_plus4_d_q;
            valid_d      = valid_q;
        end else if (bus.FlushD) begin
            instr_d      = 32'd0;
            pc_plus4_d_d = 32'd0;
            valid_d      = 1'b0;
            if (bubble_q != {CNT_W{1'b1}}) begin
                bubble_d = bubble_q + 1'b1;
            end
        end else begin
            instr_d      = bus.InstrF;
            pc_plus4_d_d = pc_plus4_f;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_q      <= 1'b0;
            bubble_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_q      <= valid_d;
            bubble_q     <= bubble_d;
        end
    end

    // All outputs come from registers; InstrF never reaches an output combinationally.
    assign bus.PCF         = pc_q;
    assign bus.InstrD      = instr_q;
    assign bus.PCPlus4D    = pc_plus4_d_q;
    assign bus.OpD         = instr_q[31:26];
    assign bus.FunctD      = instr_q[5:0];
    assign bus.ValidD      = valid_q;
    assign bus.BubbleCount = bubble_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: reference model of PC/IF-ID behaviour checked
// every cycle, plus directed scenarios with literal expected values.
module tb_fetch_decode_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   chk_en;

  fetch_decode_stage_if #(.CNT_W(16)) bus();

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents; a few fixed words, the rest derived from the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0008: imem = 32'h1085_000F;
      32'h1000_0004: imem = 32'h0800_0040;
      default:       imem = a ^ 32'h2108_5A5A;
    endcase
  endfunction

  assign bus.InstrF = imem(bus.PCF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_bub;

  always @(posedge clk) begin
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid;
    logic [15:0] n_bub;
    if (rst) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; n_bub = 16'h0;
    end else begin
      n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_bub = m_bub;
      if (!bus.StallF) begin
        if (bus.JumpD)       n_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else if (bus.PCSrcD) n_pc = bus.PCBranchD;
        else                 n_pc = m_pc + 32'd4;
      end
      if (!bus.StallD) begin
        if (bus.FlushD) begin
          n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
          if (m_bub != 16'hFFFF) n_bub = m_bub + 16'd1;
        end else begin
          n_instr = imem(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
        end
      end
    end
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_bub = n_bub;
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pcf",    bus.PCF,             m_pc);
      chk("m_instrd", bus.InstrD,          m_instr);
      chk("m_pc4d",   bus.PCPlus4D,        m_pc4);
      chk("m_opd",    {26'd0, bus.OpD},    {26'd0, m_instr[31:26]});
      chk("m_functd", {26'd0, bus.FunctD}, {26'd0, m_instr[5:0]});
      chk("m_validd", {31'd0, bus.ValidD}, {31'd0, m_valid});
      chk("m_bubble", {16'd0, bus.BubbleCount}, {16'd0, m_bub});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fd,
                       input logic br, input logic [31:0] tgt, input logic jp);
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.FlushD    = fd;
    bus.PCSrcD    = br;
    bus.PCBranchD = tgt;
    bus.JumpD     = jp;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0);

    // Reset held two cycles, then sequential fetch
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pcf",    bus.PCF, 32'h0);
    chk("rst_instrd", bus.InstrD, 32'h0);
    chk("rst_validd", {31'd0, bus.ValidD}, 32'h0);
    chk("rst_bubble", {16'd0, bus.BubbleCount}, 32'h0);
    tick();
    chk("seq_pcf_4",   bus.PCF, 32'h4);
    chk("seq_instrd0", bus.InstrD, 32'h2108_5A5A);
    chk("seq_pc4d_4",  bus.PCPlus4D, 32'h4);
    chk("seq_validd",  {31'd0, bus.ValidD}, 32'h1);
    tick();
    chk("seq_pcf_8",   bus.PCF, 32'h8);
    tick();
    chk("seq_pcf_c",   bus.PCF, 32'hC);
    chk("seq_beq_in_d", bus.InstrD, 32'h1085_000F);

    // Taken branch with flush
    drive(0, 0, 1, 1, 32'h40, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("br_pcf",    bus.PCF, 32'h40);
    chk("br_instrd", bus.InstrD, 32'h0);
    chk("br_validd", {31'd0, bus.ValidD}, 32'h0);
    chk("br_bubble", {16'd0, bus.BubbleCount}, 32'h1);
    tick();
    chk("br_target_instr", bus.InstrD, 32'h2108_5A1A);

    // Jump beats branch
    drive(0, 0, 1, 1, 32'h1000_0004, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    tick();
    chk("j_instrd", bus.InstrD, 32'h0800_0040);
    chk("j_pc4d",   bus.PCPlus4D, 32'h1000_0008);
    chk("j_opd",    {26'd0, bus.OpD}, 32'h2);
    drive(0, 0, 1, 1, 32'h200, 1);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("j_pcf",    bus.PCF, 32'h1000_0100);
    chk("j_bubble", {16'd0, bus.BubbleCount}, 32'h3);

    // Stall for three cycles with flush and branch asserted
    tick();
    drive(1, 1, 1, 1, 32'h80, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pcf",    bus.PCF, 32'h1000_0104);
      chk("stall_instrd", bus.InstrD, imem(32'h1000_0100));
      chk("stall_validd", {31'd0, bus.ValidD}, 32'h1);
      chk("stall_bubble", {16'd0, bus.BubbleCount}, 32'h3);
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    tick();
    chk("unstall_pcf",    bus.PCF, 32'h1000_0108);
    chk("unstall_instrd", bus.InstrD, imem(32'h1000_0104));

    // PC wraps from the top of the address space
    drive(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("wrap_pcf_top", bus.PCF, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pcf",    bus.PCF, 32'h0);
    chk("wrap_pc4d",   bus.PCPlus4D, 32'h0);
    chk("wrap_validd", {31'd0, bus.ValidD}, 32'h1);
    chk("wrap_instrd", bus.InstrD, 32'hDEF7_A5A6);

    // Saturate the bubble counter, then reset in the middle of a flush/redirect
    drive(0, 0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 65536; i++) tick();
    chk("sat_bubble", {16'd0, bus.BubbleCount}, 32'h0000_FFFF);
    rst = 1'b1;
    drive(0, 0, 1, 1, 32'h300, 0);
    tick();
    chk("rst2_pcf",    bus.PCF, 32'h0);
    chk("rst2_instrd", bus.InstrD, 32'h0);
    chk("rst2_pc4d",   bus.PCPlus4D, 32'h0);
    chk("rst2_validd", {31'd0, bus.ValidD}, 32'h0);
    chk("rst2_bubble", {16'd0, bus.BubbleCount}, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    tick();
    chk("post_rst_pcf", bus.PCF, 32'h4);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
